// File: rtl/c7552_resp_checker.sv
// Response checker for the c7552 benchmark: pairs each DUT response with a golden
// vector and tracks errors. Define RESP_MISR_EN to build the 32-bit MISR on misr_sig.
module c7552_resp_checker #(
  parameter int RESP_W  = 108,
  parameter int NUM_VEC = 7,
  parameter int IDX_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              resp_valid,
  input  logic [RESP_W-1:0] resp_data,
  input  logic              exp_valid,
  output logic              exp_ready,
  input  logic [RESP_W-1:0] exp_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              underrun,
  output logic [IDX_W-1:0]  err_count,
  output logic [IDX_W-1:0]  first_err_idx,
  output logic [RESP_W-1:0] first_err_mask,
  output logic [31:0]       misr_sig
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_VEC);

  state_t            state, state_nxt;
  logic              buf_valid;
  logic [RESP_W-1:0] buf_data;
  logic [IDX_W-1:0]  cmp_cnt;   // compares issued this run
  logic [IDX_W-1:0]  ret_cnt;   // compares retired through stage 2
  logic              s1_valid;
  logic [RESP_W-1:0] s1_mask;
  logic [IDX_W-1:0]  s1_idx;
`ifdef RESP_MISR_EN
  logic [RESP_W-1:0] s1_data;
`endif

  logic              run, start_ok, take, fire, golden_ok;
  logic [RESP_W-1:0] golden, cmp_mask;

  assign run       = (state == S_RUN);
  assign start_ok  = start && (state == S_IDLE || state == S_DONE);
  assign exp_ready = run && !buf_valid && (cmp_cnt < LAST);
  assign take      = exp_valid && exp_ready;
  assign fire      = resp_valid && run && (cmp_cnt < LAST);
  // A same-cycle transfer bypasses the buffer when it is empty.
  assign golden_ok = buf_valid || take;
  assign golden    = buf_valid ? buf_data : exp_data;
  assign cmp_mask  = golden_ok ? (resp_data ^ golden) : '1;

  assign busy = run || s1_valid;
  assign done = (state == S_DONE);
  assign pass = done && (err_count == '0) && !underrun;

  always_comb begin
    // NOTE: defaulting every always_comb output first keeps the block free of inferred latches.
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (ret_cnt == LAST) state_nxt = S_DONE;
      S_DONE:  if (start) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      buf_valid      <= 1'b0;
      cmp_cnt        <= '0;
      ret_cnt        <= '0;
      s1_valid       <= 1'b0;
      underrun       <= 1'b0;
      err_count      <= '0;
      first_err_idx  <= '0;
      first_err_mask <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        buf_valid      <= 1'b0;
        cmp_cnt        <= '0;
        ret_cnt        <= '0;
        s1_valid       <= 1'b0;
        underrun       <= 1'b0;
        err_count      <= '0;
        first_err_idx  <= '0;
        first_err_mask <= '0;
      end else begin
        s1_valid <= fire;
        if (fire) begin
          cmp_cnt <= cmp_cnt + 1'b1;
          if (!golden_ok) underrun <= 1'b1;
        end
        if (fire)      buf_valid <= 1'b0;
        else if (take) buf_valid <= 1'b1;
        if (s1_valid) begin
          ret_cnt <= ret_cnt + 1'b1;
          if (|s1_mask) begin
            if (err_count != '1) err_count <= err_count + 1'b1;
            // err_count saturates and never wraps, so zero means no mismatch yet.
            if (err_count == '0) begin
              first_err_idx  <= s1_idx;
              first_err_mask <= s1_mask;
            end
          end
        end
      end
    end
  end

  // NOTE: pure datapath registers are qualified by valid flags, so they carry no reset.
  always_ff @(posedge clk) begin
    if (take) buf_data <= exp_data;
    if (fire) begin
      s1_mask <= cmp_mask;
      s1_idx  <= cmp_cnt;
`ifdef RESP_MISR_EN
      s1_data <= resp_data;
`endif
    end
  end

`ifdef RESP_MISR_EN
  logic [127:0] s1_ext;
  logic [31:0]  fold, sig;

  assign s1_ext = 128'(s1_data);
  assign fold   = s1_ext[31:0] ^ s1_ext[63:32] ^ s1_ext[95:64] ^ s1_ext[127:96];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        sig <= '0;
    else if (start_ok) sig <= 32'hFFFF_FFFF;
    else if (s1_valid) sig <= {sig[30:0], sig[31] ^ sig[21] ^ sig[1] ^ sig[0]} ^ fold;
  end

  assign misr_sig = sig;
`else
  assign misr_sig = '0;
`endif

endmodule
